serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: diff = a - b - bin_in, one bit per clock, LSB first.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_subtractor_fs_cell.sv | 17 +
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Bit counter must be able to hold values 0..WIDTH.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full-subtract cell: d = a - b - bin, bout = borrow out of this bit.
module fs_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  // Purely combinational difference and borrow.
  assign w_axb  = i_a ^ i_b;
  assign o_d    = w_axb ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | computing one result bit per cycle
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  // r_a doubles as the result shift register: each computed bit enters at
  // the MSB as the consumed minuend bit leaves at the LSB.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  fs_cell u_fs_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result latch on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_br   <= bin_in;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_a   <= {w_d, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_br  <= w_bout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= {w_d, r_a[WIDTH-1:1]};
        r_bout <= w_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during SHIFT, so keep copies for the
  // overflow decision made on the final bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h expected=none", diff);
      end else begin
        m_e = sb_q.pop_front();
        chk("sb_diff", {24'd0, diff}, {24'd0, m_e.d});
        chk("sb_borrow", {31'd0, borrow_out}, {31'd0, m_e.bo});
`ifdef SERIAL_SUB_OVF_EN
        chk("sb_ovf", {31'd0, ovf}, {31'd0, m_e.ov});
`endif
      end
    end
  end

  // Drive operands and raise start; expected result goes to the scoreboard.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic [7:0] ed, input logic ebo, input logic eov);
    a      = ia;
    b      = ib;
    bin_in = ibin;
    start  = 1'b1;
    sb_q.push_back({ed, ebo, eov});
  endtask

  // Wait (bounded) for done; latency counted in edges from the accepting edge.
  task automatic wait_done(input string nm, input int exp_lat, input int first_i);
    int k;
    k = 0;
    for (int i = first_i; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({nm, "_latency"}, k, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic subtract and latency
    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    wait_done("t1", 9, 1);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_diff_hold", {24'd0, diff}, 32'h1E);

    // 2: wrap below zero
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    wait_done("t2", 9, 1);
    @(negedge clk);

    // 3: borrow-in with equal operands, then back-to-back start in DONE
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_done("t3", 9, 1);
    issue(8'h10, 8'h0F, 1'b0, 8'h01, 1'b0, 1'b0);
    wait_done("t3b", 9, 1);
    @(negedge clk);

    // 4: start while busy must be ignored; diff held mid-shift
    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_diff_midshift", {24'd0, diff}, 32'h01);
    a      = 8'h00;
    b      = 8'hFF;
    bin_in = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", 9, 4);
    @(negedge clk);

    // 5: reset mid-operation aborts with no done pulse
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_diff", {24'd0, diff}, 32'd0);
    chk("t5_borrow", {31'd0, borrow_out}, 32'd0);
    sb_q.delete();
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("t5_no_done", n_done, 0);

    // 6: overflow cases and further boundaries
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_done("t6a", 9, 1);
    @(negedge clk);
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done("t6b", 9, 1);
    @(negedge clk);
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    wait_done("t6c", 9, 1);
    @(negedge clk);
    issue(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0);
    wait_done("t6d", 9, 1);
    @(negedge clk);
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_done("t6e", 9, 1);
    repeat (2) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
